// File: rtl/pixel_row_readout.sv
// pixel_row_readout
//   Consumer end of the pixel array row-read bus. It watches the one-hot row
//   select that the sensor controller drives. It captures each newly selected
//   row's packed word into a small row FIFO. The buffered rows then leave as
//   one pixel per valid/ready transfer, tagged with frame and line markers.
//
// Ports
//   clk        system clock, all state changes on posedge
//   reset      asynchronous, active-high, clears all state
//   read       one-hot row select from the controller (all-zero = idle)
//   row_data   packed row word, column c at [c*PIXEL_BITS +: PIXEL_BITS]
//   out_data   current pixel value
//   out_valid  out_data and markers are valid
//   out_ready  downstream accepts; transfer = out_valid && out_ready
//   out_sof    current pixel is row 0, column 0
//   out_eol    current pixel is the last column of its row
//   out_eof    current pixel is the last column of the last row
//   out_row    row index of the current pixel
//   overflow   sticky, a captured row was dropped because the FIFO was full
//   sel_error  sticky, a non-zero, non-one-hot select was observed
//   busy       FIFO non-empty or serialiser active

module pixel_row_readout #(
  parameter int PIXEL_ARRAY_WIDTH  = 2,
  parameter int PIXEL_ARRAY_HEIGHT = 2,
  parameter int PIXEL_BITS         = 8,
  parameter int ROW_FIFO_DEPTH     = 2,
  localparam int ROW_BITS = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [PIXEL_ARRAY_HEIGHT-1:0]         read,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] row_data,
  output logic [PIXEL_BITS-1:0]                 out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_sof,
  output logic                                  out_eol,
  output logic                                  out_eof,
  output logic [ROW_BITS-1:0]                   out_row,
  output logic                                  overflow,
  output logic                                  sel_error,
  output logic                                  busy
);

  localparam int WORD_BITS = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
  localparam int COL_BITS  = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1;
  localparam int PTR_BITS  = $clog2(ROW_FIFO_DEPTH);
  localparam int CNT_BITS  = PTR_BITS + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Select history and capture detection
  // ---------------------------------------------------------------------------
  logic [PIXEL_ARRAY_HEIGHT-1:0] read_q_reg;
  logic [PIXEL_ARRAY_HEIGHT-1:0] read_q2_reg;
  logic                          read_onehot;
  logic                          read_bad;
  logic                          capture;
  logic [ROW_BITS-1:0]           row_terms [PIXEL_ARRAY_HEIGHT];
  logic [ROW_BITS-1:0]           capture_row;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_q_reg  <= '0;
      read_q2_reg <= '0;
    end else begin
      read_q_reg  <= read;
      read_q2_reg <= read_q_reg;
    end
  end

  // x & (x-1) clears the lowest set bit, so it is zero only for a single set bit.
  assign read_onehot = (read_q_reg != '0) &&
                       ((read_q_reg & (read_q_reg - PIXEL_ARRAY_HEIGHT'(1))) == '0);
  assign read_bad    = (read_q_reg != '0) && !read_onehot;
  // A capture fires only on the first registered cycle of a new select. A row
  // held for many cycles is therefore taken once. A return via zero retriggers.
  assign capture     = read_onehot && (read_q_reg != read_q2_reg);

  // One-hot to binary. OR-ing the per-bit terms is exact because at most one
  // bit is set whenever the result is used.
  for (genvar gi = 0; gi < PIXEL_ARRAY_HEIGHT; gi++) begin : g_row_enc
    assign row_terms[gi] = read_q_reg[gi] ? ROW_BITS'(gi) : '0;
  end

  always_comb begin
    capture_row = '0;
    for (int i = 0; i < PIXEL_ARRAY_HEIGHT; i++) begin
      capture_row = capture_row | row_terms[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Row FIFO
  // ---------------------------------------------------------------------------
  logic [ROW_BITS-1:0]  mem_row  [ROW_FIFO_DEPTH];
  logic [WORD_BITS-1:0] mem_word [ROW_FIFO_DEPTH];
  logic [PTR_BITS-1:0]  rd_ptr_reg;
  logic [PTR_BITS-1:0]  wr_ptr_reg;
  logic [PTR_BITS-1:0]  rd_ptr_next;
  logic [CNT_BITS-1:0]  count_reg;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  logic                 transfer;
  logic                 last_col;
  logic                 overflow_reg;
  logic                 sel_error_reg;

  state_t               state_reg;
  logic [WORD_BITS-1:0] word_reg;
  logic [ROW_BITS-1:0]  row_reg;
  logic [COL_BITS-1:0]  col_reg;

  assign fifo_empty  = (count_reg == '0);
  assign fifo_full   = (count_reg == CNT_BITS'(ROW_FIFO_DEPTH));
  assign rd_ptr_next = rd_ptr_reg + 1'b1;

  assign transfer = (state_reg == SHIFT) && out_ready;
  assign last_col = (col_reg == COL_BITS'(PIXEL_ARRAY_WIDTH - 1));
  // The head entry stays in the FIFO while its row is shifted out. It is
  // released on the transfer of its last column, so the FIFO occupancy counts
  // the row currently on the output.
  assign pop      = transfer && last_col;
  // A full FIFO still takes a new row when the head leaves on the same edge.
  assign push     = capture && (!fifo_full || pop);

  // Storage is written only; no reset needed on the data itself.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_row[wr_ptr_reg]  <= capture_row;
      mem_word[wr_ptr_reg] <= row_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      sel_error_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_next;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (capture && !push) begin
        overflow_reg <= 1'b1;
      end
      if (read_bad) begin
        sel_error_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      word_reg  <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            word_reg  <= mem_word[rd_ptr_reg];
            row_reg   <= mem_row[rd_ptr_reg];
            col_reg   <= '0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (transfer) begin
            if (!last_col) begin
              col_reg <= col_reg + 1'b1;
            end else if (count_reg > CNT_BITS'(1)) begin
              // Another row is already buffered behind the head.
              word_reg <= mem_word[rd_ptr_next];
              row_reg  <= mem_row[rd_ptr_next];
              col_reg  <= '0;
            end else if (push) begin
              // The only follow-on row is arriving on this edge. Bypass the
              // memory to avoid a bubble.
              word_reg <= row_data;
              row_reg  <= capture_row;
              col_reg  <= '0;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Pixel view of the loaded row word.
  logic [PIXEL_BITS-1:0] pixels [PIXEL_ARRAY_WIDTH];

  for (genvar gi = 0; gi < PIXEL_ARRAY_WIDTH; gi++) begin : g_pix
    assign pixels[gi] = word_reg[gi*PIXEL_BITS +: PIXEL_BITS];
  end

  // Outputs decode only registered state. They follow an asynchronous reset
  // at once and stay stable while a transfer is stalled. Data and markers are
  // forced low while nothing is being presented.
  assign out_valid = (state_reg == SHIFT);
  assign out_data  = out_valid ? pixels[col_reg] : '0;
  assign out_row   = out_valid ? row_reg : '0;
  assign out_eol   = out_valid && last_col;
  assign out_sof   = out_valid && (row_reg == '0) && (col_reg == '0);
  assign out_eof   = out_valid && last_col &&
                     (row_reg == ROW_BITS'(PIXEL_ARRAY_HEIGHT - 1));
  assign overflow  = overflow_reg;
  assign sel_error = sel_error_reg;
  assign busy      = !fifo_empty || (state_reg == SHIFT);

endmodule

// File: tb/tb_pixel_row_readout.sv
// Self-checking bench for pixel_row_readout. It applies directed frames
// followed by randomized row selects, row words and backpressure. Each cycle
// it compares the DUT against a queue-based reference model of buffered rows.

module tb_pixel_row_readout;

  localparam int W  = 2;
  localparam int H  = 2;
  localparam int B  = 8;
  localparam int D  = 2;
  localparam int WB = W * B;
  localparam int RB = (H > 1) ? $clog2(H) : 1;

  logic          clk;
  logic          reset;
  logic [H-1:0]  read;
  logic [WB-1:0] row_data;
  logic [B-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;
  logic [RB-1:0] out_row;
  logic          overflow;
  logic          sel_error;
  logic          busy;

  pixel_row_readout #(
    .PIXEL_ARRAY_WIDTH (W),
    .PIXEL_ARRAY_HEIGHT(H),
    .PIXEL_BITS        (B),
    .ROW_FIFO_DEPTH    (D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .read     (read),
    .row_data (row_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sof  (out_sof),
    .out_eol  (out_eol),
    .out_eof  (out_eof),
    .out_row  (out_row),
    .overflow (overflow),
    .sel_error(sel_error),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // q holds every accepted row not yet fully sent, including the row on the
  // output. m_loaded says a row is being presented; m_col is its next column.
  typedef struct {
    int            row;
    logic [WB-1:0] word;
  } row_t;

  row_t         q[$];
  logic [H-1:0] m_rq, m_rq2;
  bit           m_loaded;
  int           m_col;
  bit           m_ovf, m_sel;

  function automatic int onehot_index(input logic [H-1:0] v);
    for (int i = 0; i < H; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_clear();
    q.delete();
    m_rq = '0; m_rq2 = '0;
    m_loaded = 0; m_col = 0;
    m_ovf = 0; m_sel = 0;
  endtask

  // Advance the model by one clock edge using the inputs applied for it.
  task automatic model_edge();
    bit   nonempty_before;
    bit   xfer;
    bit   last;
    bit   cap;
    row_t e;
    nonempty_before = (q.size() > 0);
    xfer = m_loaded && out_ready;
    last = xfer && (m_col == W - 1);
    cap  = ($countones(m_rq) == 1) && (m_rq != m_rq2);
    if (m_rq != '0 && $countones(m_rq) != 1) m_sel = 1;
    if (xfer)
      $display("xfer row=%0d col=%0d data=%02h", q[0].row, m_col, q[0].word[m_col*B +: B]);
    if (last) q.delete(0);
    if (cap) begin
      if (q.size() < D) begin
        e.row = onehot_index(m_rq);
        e.word = row_data;
        q.push_back(e);
      end else begin
        m_ovf = 1;
      end
    end
    if (last) begin
      m_col = 0;
      m_loaded = (q.size() > 0);
    end else if (xfer) begin
      m_col++;
    end else if (!m_loaded && nonempty_before) begin
      m_loaded = 1;
      m_col = 0;
    end
    m_rq2 = m_rq;
    m_rq = read;
  endtask

  task automatic compare_outputs();
    check("valid", out_valid, m_loaded);
    if (m_loaded) begin
      check("data", out_data, q[0].word[m_col*B +: B]);
      check("row",  out_row, q[0].row);
      check("sof",  out_sof, (q[0].row == 0) && (m_col == 0));
      check("eol",  out_eol, (m_col == W - 1));
      check("eof",  out_eof, (q[0].row == H - 1) && (m_col == W - 1));
    end
    check("overflow",  overflow,  m_ovf);
    check("sel_error", sel_error, m_sel);
    check("busy",      busy,      q.size() > 0);
  endtask

  task automatic check_all_zero();
    check("rst_valid", out_valid, 0);
    check("rst_data",  out_data,  0);
    check("rst_sof",   out_sof,   0);
    check("rst_eol",   out_eol,   0);
    check("rst_eof",   out_eof,   0);
    check("rst_row",   out_row,   0);
    check("rst_ovf",   overflow,  0);
    check("rst_sel",   sel_error, 0);
    check("rst_busy",  busy,      0);
  endtask

  // One clock: check at negedge, drive new inputs, let the edge happen.
  task automatic step(input logic [H-1:0] r, input logic [WB-1:0] d, input logic rdy);
    @(negedge clk);
    compare_outputs();
    read = r;
    row_data = d;
    out_ready = rdy;
    @(posedge clk);
    model_edge();
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic reset_async();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero();
    read = '0;
    out_ready = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) step('0, '0, 1'b1);
  endtask

  initial begin
    logic [H-1:0]  r;
    logic [WB-1:0] d;
    int            pick;
    int            hold;

    clk = 0; reset = 1; read = '0; row_data = '0; out_ready = 0;
    model_clear();
    #1;
    check_all_zero();
    repeat (3) @(negedge clk);
    reset = 0;

    // Nominal frame.
    repeat (5) step(2'b01, 16'hBBAA, 1'b1);
    repeat (5) step(2'b10, 16'hDDCC, 1'b1);
    drain(4);

    // Backpressure while the first pixel is presented.
    repeat (2) step(2'b01, 16'hBBAA, 1'b1);
    repeat (4) step(2'b01, 16'hBBAA, 1'b0);
    step(2'b01, 16'hBBAA, 1'b1);
    repeat (5) step(2'b10, 16'hDDCC, 1'b1);
    drain(4);

    // Overflow with the output stalled, then release.
    repeat (2) step(2'b01, 16'h1111, 1'b0);
    repeat (2) step(2'b10, 16'h2222, 1'b0);
    repeat (2) step(2'b01, 16'h3333, 1'b0);
    repeat (2) step('0, '0, 1'b0);
    drain(8);

    // Full FIFO with a capture on the same edge as the head's last column.
    reset_async();
    repeat (2) step(2'b01, 16'h4444, 1'b0);
    repeat (2) step(2'b10, 16'h5555, 1'b0);
    repeat (3) step('0, '0, 1'b0);
    step(2'b01, 16'h6666, 1'b1);
    step(2'b01, 16'h6666, 1'b1);
    drain(8);

    // Select error, then a normal capture.
    repeat (3) step(2'b11, 16'hEEEE, 1'b1);
    repeat (2) step('0, '0, 1'b1);
    repeat (3) step(2'b01, 16'h7777, 1'b1);
    drain(4);

    // Reset mid-row, then a clean frame.
    reset_async();
    repeat (4) step(2'b01, 16'h9988, 1'b1);
    reset_async();
    repeat (5) step(2'b01, 16'hBBAA, 1'b1);
    repeat (5) step(2'b10, 16'hDDCC, 1'b1);
    drain(4);

    // Randomized traffic.
    for (int t = 0; t < 400; t++) begin
      pick = $urandom_range(0, 39);
      r = '0;
      if (pick < 28) r[$urandom_range(0, H - 1)] = 1'b1;
      else if (pick == 39) r = '1;
      hold = $urandom_range(1, 4);
      repeat (hold) begin
        d = WB'($urandom);
        step(r, d, $urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 59) == 0) reset_async();
    end
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
